seg7_decoder: RTL and testbench
===============================

SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 SHALL have parameter ACTIVE_LOW, default 1: 1 = input segments asserted low, 0 = asserted high.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, legal range 1..65535: consecutive identical synchronized samples required before a pattern is accepted.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock; all logic on rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_seg, input, 7 bits: asynchronous segment lines; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-006 SHALL have port o_val, output, 4 bits: decoded hex digit of the last accepted pattern.
REQ-007 SHALL have port o_is_dec, output, 1 bit: high when the accepted glyph is a digit in the range 0-9.
REQ-008 SHALL have port o_blank, output, 1 bit: high when the accepted pattern has all segments off.
REQ-009 SHALL have port o_invalid, output, 1 bit: high when the accepted pattern is neither a glyph nor blank.
REQ-010 SHALL have port o_valid, output, 1 bit: one-cycle strobe marking a newly accepted, changed pattern.
REQ-011 SHALL have port o_locked, output, 1 bit: high while the input matches the accepted pattern.

Function
REQ-012 i_seg SHALL pass through a 2-flop synchronizer, then be normalized to active-high (inverted when ACTIVE_LOW=1) to form pattern p.
REQ-013 Glyph table, active-high hex: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71; 00=blank; every other value is invalid.
REQ-014 FSM SHALL have 2 states, SETTLE and LOCKED.
REQ-015 In SETTLE: a 16-bit counter SHALL increment while p equals the previous p, and SHALL reset to 0 when p differs.
REQ-016 In SETTLE: when the counter reaches STABLE_CYCLES-1 with p unchanged, the FSM SHALL go to LOCKED.
REQ-017 On entry to LOCKED with p different from the held pattern, the block SHALL register p as the held pattern, update o_val, o_is_dec, o_blank and o_invalid together, and pulse o_valid for exactly 1 cycle coincident with the updated outputs.
REQ-018 On entry to LOCKED with p equal to the held pattern (glitch then return), outputs SHALL stay unchanged and o_valid SHALL NOT pulse.
REQ-019 In LOCKED: any change of p SHALL return the FSM to SETTLE with counter=0 on the next cycle; decoded outputs SHALL hold their prior values.
REQ-020 o_locked SHALL be 1 exactly while the state is LOCKED.
REQ-021 Latency: from the i_seg change to the o_valid pulse SHALL be 2 (sync) + STABLE_CYCLES + 1 cycles for a clean step.
REQ-022 With STABLE_CYCLES=1, any single sample differing from the held pattern SHALL be accepted on the following cycle.
REQ-023 For blank or invalid patterns, o_val SHALL be 0 and o_is_dec 0.
REQ-024 The counter SHALL never wrap; it stops at STABLE_CYCLES-1.

Reset
REQ-025 While i_reset=1: synchronizer flops SHALL load the "all segments off" level, FSM=SETTLE, counter=0, held pattern=00, o_val=0, o_is_dec=0, o_blank=1, o_invalid=0, o_valid=0, o_locked=0.
REQ-026 Reset asserted mid-settle or during an o_valid cycle SHALL take effect on that clock edge; no o_valid pulse SHALL follow reset release unless a non-blank pattern is newly accepted.

Structure
REQ-027 A shared package seg7_pkg SHALL hold the 16 glyph constants, the blank constant, the FSM state encoding and the segment bit-index constants, shared with the existing BCD-to-7-segment encoder.
REQ-028 A combinational sub-module seg7_glyph_lookup (7-bit pattern in; val, is_dec, blank, invalid out) SHALL implement REQ-013; seg7_decoder SHALL contain the synchronizer, counter, FSM and output registers.

Verification
REQ-029 Reset, then i_seg=~7'h5B held (ACTIVE_LOW=1, STABLE_CYCLES=4) -> o_valid pulses 1 cycle at cycle 7 after the change; o_val=2, o_is_dec=1, o_locked=1.
REQ-030 Drive the encoder-generated patterns for 0..F in sequence, each held 20 cycles -> 16 o_valid pulses; o_val follows 0..F; o_is_dec high for 0..9 only.
REQ-031 While locked on 8, a 2-cycle glitch to 7F^01 -> o_locked drops, outputs unchanged, no o_valid pulse after relock.
REQ-032 Pattern toggles between 06 and 4F every 3 cycles with STABLE_CYCLES=4 -> never locks, no o_valid pulse, outputs hold.
REQ-033 Stable 7'h01 -> o_invalid=1, o_val=0, 1 o_valid pulse; then all-off -> o_blank=1, 1 o_valid pulse.
REQ-034 i_reset asserted 2 cycles into settling on 9 -> all outputs at reset values next cycle; 9 is re-accepted with full latency measured from release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph codes, segment bit positions and
// decoder FSM encoding, common to the BCD encoder and the segment decoder.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high glyph codes, bit0 = segment a ... bit6 = segment g.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } seg7_state_e;

    function automatic logic [6:0] seg7_encode(input logic [3:0] hex);
        logic [6:0] pat;
        case (hex)
            4'h0: pat = GLYPH_0;
            4'h1: pat = GLYPH_1;
            4'h2: pat = GLYPH_2;
            4'h3: pat = GLYPH_3;
            4'h4: pat = GLYPH_4;
            4'h5: pat = GLYPH_5;
            4'h6: pat = GLYPH_6;
            4'h7: pat = GLYPH_7;
            4'h8: pat = GLYPH_8;
            4'h9: pat = GLYPH_9;
            4'hA: pat = GLYPH_A;
            4'hB: pat = GLYPH_B;
            4'hC: pat = GLYPH_C;
            4'hD: pat = GLYPH_D;
            4'hE: pat = GLYPH_E;
            default: pat = GLYPH_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decoder_if.sv
// Decoder-side signal bundle: segment lines toward the decoder and the
// decoded digit/status back from it.
interface seg7_decoder_if;
    logic [6:0] seg;
    logic [3:0] val;
    logic       is_dec;
    logic       blank;
    logic       invalid;
    logic       valid;
    logic       locked;

    modport master (
        output seg,
        input  val, is_dec, blank, invalid, valid, locked
    );

    modport slave (
        input  seg,
        output val, is_dec, blank, invalid, valid, locked
    );
endinterface

// File: rtl/seg7_glyph_lookup.sv
// Combinational classifier of an active-high segment pattern into hex value,
// decimal flag, blank flag and invalid flag.
module seg7_glyph_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] val_o,
    output logic       is_dec_o,
    output logic       blank_o,
    output logic       invalid_o
);

    always_comb begin
        val_o     = 4'h0;
        is_dec_o  = 1'b0;
        blank_o   = 1'b0;
        invalid_o = 1'b0;
        case (pattern_i)
            GLYPH_0: begin val_o = 4'h0; is_dec_o = 1'b1; end
            GLYPH_1: begin val_o = 4'h1; is_dec_o = 1'b1; end
            GLYPH_2: begin val_o = 4'h2; is_dec_o = 1'b1; end
            GLYPH_3: begin val_o = 4'h3; is_dec_o = 1'b1; end
            GLYPH_4: begin val_o = 4'h4; is_dec_o = 1'b1; end
            GLYPH_5: begin val_o = 4'h5; is_dec_o = 1'b1; end
            GLYPH_6: begin val_o = 4'h6; is_dec_o = 1'b1; end
            GLYPH_7: begin val_o = 4'h7; is_dec_o = 1'b1; end
            GLYPH_8: begin val_o = 4'h8; is_dec_o = 1'b1; end
            GLYPH_9: begin val_o = 4'h9; is_dec_o = 1'b1; end
            GLYPH_A: val_o = 4'hA;
            GLYPH_B: val_o = 4'hB;
            GLYPH_C: val_o = 4'hC;
            GLYPH_D: val_o = 4'hD;
            GLYPH_E: val_o = 4'hE;
            GLYPH_F: val_o = 4'hF;
            SEG_BLANK: blank_o = 1'b1;
            default: invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_decoder.sv
// Seven-segment line decoder: synchronizes the segment lines, debounces them
// and reports the accepted glyph with a change strobe.
//
// state     | meaning
// ST_SETTLE | candidate pattern being counted toward STABLE_CYCLES samples
// ST_LOCKED | input matches the held pattern
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [6:0] i_seg,
    output logic [3:0] o_val,
    output logic       o_is_dec,
    output logic       o_blank,
    output logic       o_invalid,
    output logic       o_valid,
    output logic       o_locked
);

    localparam logic [6:0]  OFF_LEVEL = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [15:0] CNT_LAST  = 16'(STABLE_CYCLES - 1);

    logic [6:0]  sync1_q, sync2_q;
    logic [6:0]  p;
    logic [6:0]  cand_q;
    logic [6:0]  held_q;
    logic [15:0] cnt_q;
    seg7_state_e state_q;

    logic [3:0] val_q, val_d;
    logic       is_dec_q, is_dec_d;
    logic       blank_q, blank_d;
    logic       invalid_q, invalid_d;
    logic       valid_q, locked_q;

    assign p = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // cand_q is last cycle's p; cnt_q counts how many further samples matched it,
    // so acceptance uses the candidate even if p moved on this very cycle.
    seg7_glyph_lookup u_lookup (
        .pattern_i (cand_q),
        .val_o     (val_d),
        .is_dec_o  (is_dec_d),
        .blank_o   (blank_d),
        .invalid_o (invalid_d)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q   <= OFF_LEVEL;
            sync2_q   <= OFF_LEVEL;
            cand_q    <= SEG_BLANK;
            held_q    <= SEG_BLANK;
            cnt_q     <= 16'd0;
            state_q   <= ST_SETTLE;
            val_q     <= 4'h0;
            is_dec_q  <= 1'b0;
            blank_q   <= 1'b1;
            invalid_q <= 1'b0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            sync1_q <= i_seg;
            sync2_q <= sync1_q;
            cand_q  <= p;
            valid_q <= 1'b0;
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                        cnt_q    <= 16'd0;
                        if (cand_q != held_q) begin
                            held_q    <= cand_q;
                            val_q     <= val_d;
                            is_dec_q  <= is_dec_d;
                            blank_q   <= blank_d;
                            invalid_q <= invalid_d;
                            valid_q   <= 1'b1;
                        end
                    end else if (p == cand_q) begin
                        cnt_q <= cnt_q + 16'd1;
                    end else begin
                        cnt_q <= 16'd0;
                    end
                end
                ST_LOCKED: begin
                    if (p != held_q) begin
                        state_q  <= ST_SETTLE;
                        locked_q <= 1'b0;
                        cnt_q    <= 16'd0;
                    end
                end
                default: begin
                    state_q  <= ST_SETTLE;
                    locked_q <= 1'b0;
                    cnt_q    <= 16'd0;
                end
            endcase
        end
    end

    assign o_val     = val_q;
    assign o_is_dec  = is_dec_q;
    assign o_blank   = blank_q;
    assign o_invalid = invalid_q;
    assign o_valid   = valid_q;
    assign o_locked  = locked_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder: an active-low STABLE_CYCLES=4 instance and
// an active-high STABLE_CYCLES=1 instance share clock and reset.
module tb_seg7_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_decoder_if bus_a ();
    seg7_decoder_if bus_b ();

    seg7_decoder #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(4)) u_dut_a (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_seg     (bus_a.seg),
        .o_val     (bus_a.val),
        .o_is_dec  (bus_a.is_dec),
        .o_blank   (bus_a.blank),
        .o_invalid (bus_a.invalid),
        .o_valid   (bus_a.valid),
        .o_locked  (bus_a.locked)
    );

    seg7_decoder #(.ACTIVE_LOW(1'b0), .STABLE_CYCLES(1)) u_dut_b (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_seg     (bus_b.seg),
        .o_val     (bus_b.val),
        .o_is_dec  (bus_b.is_dec),
        .o_blank   (bus_b.blank),
        .o_invalid (bus_b.invalid),
        .o_valid   (bus_b.valid),
        .o_locked  (bus_b.locked)
    );

    int n_total = 0;
    int n_bad   = 0;
    int vcnt_a  = 0;
    int vcnt_b  = 0;
    int v0, hit, pulses;
    logic drop, vchg, late, seen1;
    logic [6:0] glyph [16];

    always @(negedge clk) begin
        if (bus_a.valid === 1'b1) vcnt_a++;
        if (bus_b.valid === 1'b1) vcnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_val"},     32'(bus_a.val),     32'h0);
        check({tag, "_is_dec"},  32'(bus_a.is_dec),  32'h0);
        check({tag, "_blank"},   32'(bus_a.blank),   32'h1);
        check({tag, "_invalid"}, 32'(bus_a.invalid), 32'h0);
        check({tag, "_valid"},   32'(bus_a.valid),   32'h0);
        check({tag, "_locked"},  32'(bus_a.locked),  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        rst = 1'b1;
        bus_a.seg = 7'h7F;
        bus_b.seg = 7'h00;
        step(3);
        check_reset_a("rst");
        check("rst_b_blank", 32'(bus_b.blank), 32'h1);

        // blank after release is held pattern already: no strobe
        rst = 1'b0;
        step(10);
        check("rel_pulse_a", 32'(vcnt_a), 32'h0);
        check("rel_pulse_b", 32'(vcnt_b), 32'h0);
        check("rel_lock_a", 32'(bus_a.locked), 32'h1);
        check("rel_blank_a", 32'(bus_a.blank), 32'h1);

        bus_a.seg = ~7'h5B;
        hit = -1; pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (bus_a.valid) begin
                pulses++;
                if (hit < 0) hit = k;
            end
        end
        check("lat_a", 32'(hit), 32'd7);
        check("lat_pulses", 32'(pulses), 32'd1);
        check("lat_val", 32'(bus_a.val), 32'h2);
        check("lat_is_dec", 32'(bus_a.is_dec), 32'h1);
        check("lat_locked", 32'(bus_a.locked), 32'h1);

        v0 = vcnt_a;
        for (int d = 0; d < 16; d++) begin
            bus_a.seg = ~glyph[d];
            step(20);
            check($sformatf("sweep_val_%0d", d), 32'(bus_a.val), 32'(d));
            check($sformatf("sweep_dec_%0d", d), 32'(bus_a.is_dec), (d < 10) ? 32'h1 : 32'h0);
        end
        check("sweep_pulses", 32'(vcnt_a - v0), 32'd16);

        bus_a.seg = ~7'h7F;
        step(20);
        v0 = vcnt_a; drop = 1'b0; vchg = 1'b0;
        bus_a.seg = ~7'h7E;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            if (k == 2) bus_a.seg = ~7'h7F;
            if (!bus_a.locked) drop = 1'b1;
            if (bus_a.val != 4'h8) vchg = 1'b1;
        end
        check("glitch_drop", 32'(drop), 32'h1);
        check("glitch_valchg", 32'(vchg), 32'h0);
        check("glitch_relock", 32'(bus_a.locked), 32'h1);
        check("glitch_pulses", 32'(vcnt_a - v0), 32'h0);

        v0 = vcnt_a; late = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (k % 6 == 0) bus_a.seg = ~7'h06;
            else if (k % 6 == 3) bus_a.seg = ~7'h4F;
            step(1);
            if (k >= 8 && bus_a.locked) late = 1'b1;
        end
        check("toggle_locked", 32'(late), 32'h0);
        check("toggle_pulses", 32'(vcnt_a - v0), 32'h0);
        check("toggle_val", 32'(bus_a.val), 32'h8);
        check("toggle_is_dec", 32'(bus_a.is_dec), 32'h1);

        v0 = vcnt_a;
        bus_a.seg = ~7'h01;
        step(20);
        check("inv_invalid", 32'(bus_a.invalid), 32'h1);
        check("inv_val", 32'(bus_a.val), 32'h0);
        check("inv_is_dec", 32'(bus_a.is_dec), 32'h0);
        check("inv_blank", 32'(bus_a.blank), 32'h0);
        check("inv_pulses", 32'(vcnt_a - v0), 32'd1);
        v0 = vcnt_a;
        bus_a.seg = 7'h7F;
        step(20);
        check("blank_blank", 32'(bus_a.blank), 32'h1);
        check("blank_invalid", 32'(bus_a.invalid), 32'h0);
        check("blank_val", 32'(bus_a.val), 32'h0);
        check("blank_pulses", 32'(vcnt_a - v0), 32'd1);

        // reset two cycles into settling on 9
        bus_a.seg = ~7'h6F;
        step(2);
        rst = 1'b1;
        step(1);
        check_reset_a("midrst");
        rst = 1'b0;
        hit = -1; pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (bus_a.valid) begin
                pulses++;
                if (hit < 0) hit = k;
            end
        end
        check("midrst_lat", 32'(hit), 32'd7);
        check("midrst_pulses", 32'(pulses), 32'd1);
        check("midrst_val", 32'(bus_a.val), 32'h9);
        check("midrst_is_dec", 32'(bus_a.is_dec), 32'h1);

        // active-high, single-sample acceptance instance
        bus_b.seg = 7'h5B;
        hit = -1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (bus_b.valid && hit < 0) hit = k;
        end
        check("b_lat", 32'(hit), 32'd4);
        check("b_val", 32'(bus_b.val), 32'h2);
        v0 = vcnt_b; seen1 = 1'b0;
        bus_b.seg = 7'h06;
        step(1);
        bus_b.seg = 7'h5B;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (bus_b.val == 4'h1) seen1 = 1'b1;
        end
        check("b_single_seen", 32'(seen1), 32'h1);
        check("b_single_pulses", 32'(vcnt_b - v0), 32'd2);
        check("b_single_val", 32'(bus_b.val), 32'h2);
        check("b_single_locked", 32'(bus_b.locked), 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
